// File: rtl/bk_adder_sched_if.sv
// Client-side bundle for the shared-adder scheduler: per-requester operand ports and the result port.
interface bk_adder_sched_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 12
);
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [W:0]        rsp_sum;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_last;

    modport master (
        output req_valid, req_a, req_b, req_last, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_id, rsp_last
    );

    modport slave (
        input  req_valid, req_a, req_b, req_last, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_id, rsp_last
    );
endinterface

// File: rtl/bk_adder_sched.sv
// Round-robin scheduler sharing one external combinational 12-bit adder among NREQ requesters,
// with burst locking and a two-stage operand/response pipeline.
module bk_adder_sched #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 12
) (
    input  logic               clk,
    input  logic               rst,
    bk_adder_sched_if.slave    bus,
    output logic [2*W-1:0]     add_in,
    input  logic [W:0]         add_out,
    output logic               busy
);
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        ST_OPEN,
        ST_LOCKED
    } state_t;

    typedef struct packed {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [IDW-1:0] id;
        logic           last;
    } beat_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] rr_ptr, rr_ptr_nxt;
    logic [IDW-1:0] lock_id, lock_id_nxt;

    logic           s1_v;
    beat_t          s1;

    logic           rsp_valid_q;
    logic [W:0]     rsp_sum_q;
    logic [IDW-1:0] rsp_id_q;
    logic           rsp_last_q;

    logic            s2_go, s1_go, can_accept;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] ready_c;
    logic            acc;
    logic [IDW-1:0]  acc_id;
    beat_t           acc_beat;
    logic            found;
    int unsigned     idx;

    assign s2_go      = !rsp_valid_q || bus.rsp_ready;
    assign s1_go      = s1_v && s2_go;
    assign can_accept = !s1_v || s1_go;

    // Grant selection: cyclic search from rr_ptr when open, lock owner only when locked.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        if (state == ST_LOCKED) begin
            grant[lock_id] = 1'b1;
        end else begin
            for (int unsigned off = 0; off < NREQ; off++) begin
                idx = (32'(rr_ptr) + off) % NREQ;
                if (!found && bus.req_valid[IDW'(idx)]) begin
                    grant[IDW'(idx)] = 1'b1;
                    found            = 1'b1;
                end
            end
        end
    end

    assign ready_c       = (can_accept && !rst) ? (grant & bus.req_valid) : '0;
    assign bus.req_ready = ready_c;
    assign acc           = |ready_c;

    // Mux the granted requester's beat onto the S1 load path.
    always_comb begin
        acc_id   = '0;
        acc_beat = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (ready_c[i]) begin
                acc_id        = IDW'(i);
                acc_beat.a    = bus.req_a[i*W +: W];
                acc_beat.b    = bus.req_b[i*W +: W];
                acc_beat.id   = IDW'(i);
                acc_beat.last = bus.req_last[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_OPEN;
            rr_ptr  <= '0;
            lock_id <= '0;
        end else begin
            state   <= state_nxt;
            rr_ptr  <= rr_ptr_nxt;
            lock_id <= lock_id_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        rr_ptr_nxt  = rr_ptr;
        lock_id_nxt = lock_id;
        if (acc) begin
            rr_ptr_nxt  = (acc_id == IDW'(NREQ - 1)) ? '0 : acc_id + IDW'(1);
            lock_id_nxt = acc_id;
            state_nxt   = acc_beat.last ? ST_OPEN : ST_LOCKED;
        end
    end

    // S1: operand registers feeding the adder.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v <= 1'b0;
            s1   <= '0;
        end else if (acc) begin
            s1_v <= 1'b1;
            s1   <= acc_beat;
        end else if (s1_go) begin
            s1_v <= 1'b0;
        end
    end

    // S2: response registers; hold while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_id_q    <= '0;
            rsp_last_q  <= 1'b0;
        end else if (s1_go) begin
            rsp_valid_q <= 1'b1;
            rsp_sum_q   <= add_out;
            rsp_id_q    <= s1.id;
            rsp_last_q  <= s1.last;
        end else if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    always_comb begin
        add_in = '0;
        for (int k = 0; k < int'(W); k++) begin
            add_in[2*k]   = s1.a[k];
            add_in[2*k+1] = s1.b[k];
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_last  = rsp_last_q;
    assign busy          = s1_v || rsp_valid_q || (state == ST_LOCKED);

endmodule

// File: tb/tb_bk_adder_sched.sv
// Directed bench for bk_adder_sched: vector table for single beats plus fairness, burst-lock,
// backpressure and mid-burst reset sequences against a reference adder.
module tb_bk_adder_sched;
    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 12;

    logic           clk = 1'b0;
    logic           rst;
    logic [2*W-1:0] add_in;
    logic [W:0]     add_out;
    logic           busy;
    logic [W-1:0]   ref_a, ref_b;

    int checks = 0;
    int errors = 0;
    int n_acc;

    typedef struct {
        int unsigned    id;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] exp_add_in;
        logic [W:0]     exp_sum;
    } vec_t;

    vec_t vecs[7];

    bk_adder_sched_if #(.NREQ(NREQ), .W(W)) bus ();

    bk_adder_sched #(.NREQ(NREQ), .W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .add_in  (add_in),
        .add_out (add_out),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Reference adder: de-interleave the operand bus and add.
    always_comb begin
        ref_a = '0;
        ref_b = '0;
        for (int k = 0; k < int'(W); k++) begin
            ref_a[k] = add_in[2*k];
            ref_b[k] = add_in[2*k+1];
        end
        add_out = {1'b0, ref_a} + {1'b0, ref_b};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic last);
        bus.req_valid[i]       = v;
        bus.req_a[i*W +: W]    = a;
        bus.req_b[i*W +: W]    = b;
        bus.req_last[i]        = last;
    endtask

    task automatic chk_rsp(input string name, input logic [W:0] sum, input int id, input logic last);
        chk({name, " valid"}, 32'(bus.rsp_valid), 32'd1);
        chk({name, " sum"},   32'(bus.rsp_sum),   32'(sum));
        chk({name, " id"},    32'(bus.rsp_id),    32'(id));
        chk({name, " last"},  32'(bus.rsp_last),  32'(last));
    endtask

    initial begin
        vecs[0] = '{1, 12'hFFF, 12'h001, 24'h555557, 13'h1000};
        vecs[1] = '{0, 12'hFFF, 12'hFFF, 24'hFFFFFF, 13'h1FFE};
        vecs[2] = '{2, 12'h000, 12'h000, 24'h000000, 13'h0000};
        vecs[3] = '{3, 12'h000, 12'hFFF, 24'hAAAAAA, 13'h0FFF};
        vecs[4] = '{0, 12'h800, 12'h001, 24'h400002, 13'h0801};
        vecs[5] = '{2, 12'h0F0, 12'h00F, 24'h0055AA, 13'h00FF};
        vecs[6] = '{1, 12'h555, 12'hAAA, 24'h999999, 13'h0FFF};

        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_last  = '0;
        bus.rsp_ready = 1'b1;

        // Reset values, including req_ready held low while every requester is valid.
        #2;
        bus.req_valid = '1;
        #1;
        chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset rsp_sum",   32'(bus.rsp_sum),   32'd0);
        chk("reset rsp_id",    32'(bus.rsp_id),    32'd0);
        chk("reset rsp_last",  32'(bus.rsp_last),  32'd0);
        chk("reset add_in",    32'(add_in),        32'd0);
        chk("reset busy",      32'(busy),          32'd0);
        chk("reset req_ready", 32'(bus.req_ready), 32'd0);
        repeat (2) tick();
        chk("reset req_ready held", 32'(bus.req_ready), 32'd0);
        bus.req_valid = '0;
        rst = 1'b0;
        tick();

        // Single-beat vectors on an idle pipeline.
        for (int v = 0; v < 7; v++) begin
            set_req(int'(vecs[v].id), 1'b1, vecs[v].a, vecs[v].b, 1'b1);
            #1;
            chk("vec ready", 32'(bus.req_ready), 32'(1) << vecs[v].id);
            tick();
            set_req(int'(vecs[v].id), 1'b0, '0, '0, 1'b0);
            chk("vec add_in", 32'(add_in), 32'(vecs[v].exp_add_in));
            chk("vec rsp not yet", 32'(bus.rsp_valid), 32'd0);
            tick();
            chk_rsp("vec rsp", vecs[v].exp_sum, int'(vecs[v].id), 1'b1);
            tick();
            chk("vec drained", 32'(bus.rsp_valid), 32'd0);
            chk("vec idle busy", 32'(busy), 32'd0);
        end

        // Fairness: all requesters valid, single beats, consumer always ready.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int r = 0; r < 4; r++) set_req(r, 1'b1, 12'(r), 12'h010, 1'b1);
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("rr grant", 32'(bus.req_ready), 32'(1) << (c % 4));
            tick();
            if (c >= 1) chk_rsp("rr rsp", 13'(16 + ((c - 1) % 4)), (c - 1) % 4, 1'b1);
        end
        bus.req_valid = '0;
        tick();
        chk_rsp("rr rsp tail", 13'h011, 1, 1'b1);
        tick();
        chk("rr drained", 32'(bus.rsp_valid), 32'd0);

        // Burst lock: requester 2 (at rr_ptr) holds the adder for 3 beats against requester 0.
        set_req(0, 1'b1, 12'h001, 12'h001, 1'b1);
        set_req(2, 1'b1, 12'h100, 12'h001, 1'b0);
        #1;
        chk("burst beat0 grant", 32'(bus.req_ready), 32'h4);
        tick();
        set_req(2, 1'b1, 12'h200, 12'h002, 1'b0);
        #1;
        chk("burst beat1 grant", 32'(bus.req_ready), 32'h4);
        tick();
        chk_rsp("burst rsp0", 13'h101, 2, 1'b0);
        set_req(2, 1'b0, 12'h000, 12'h000, 1'b0);
        #1;
        chk("burst lock holds", 32'(bus.req_ready), 32'h0);
        chk("burst busy", 32'(busy), 32'd1);
        tick();
        chk_rsp("burst rsp1", 13'h202, 2, 1'b0);
        set_req(2, 1'b1, 12'h300, 12'h003, 1'b1);
        #1;
        chk("burst beat2 grant", 32'(bus.req_ready), 32'h4);
        tick();
        set_req(2, 1'b0, 12'h000, 12'h000, 1'b0);
        #1;
        chk("post-burst grant", 32'(bus.req_ready), 32'h1);
        tick();
        set_req(0, 1'b0, 12'h000, 12'h000, 1'b0);
        chk_rsp("burst rsp2", 13'h303, 2, 1'b1);
        tick();
        chk_rsp("post-burst rsp", 13'h002, 0, 1'b1);
        tick();
        chk("burst drained", 32'(bus.rsp_valid), 32'd0);

        // Backpressure: consumer stalls; only two beats fit in the pipeline.
        bus.rsp_ready = 1'b0;
        n_acc = 0;
        for (int c = 0; c < 5; c++) begin
            set_req(0, 1'b1, 12'(32'h100 + n_acc), 12'h000, 1'b1);
            #1;
            chk("bp ready", 32'(bus.req_ready), (c < 2) ? 32'h1 : 32'h0);
            if (bus.req_ready[0]) n_acc++;
            tick();
            if (c >= 1) begin
                chk("bp sum stable", 32'(bus.rsp_sum), 32'h100);
                chk("bp valid", 32'(bus.rsp_valid), 32'd1);
            end
        end
        chk("bp accepted", 32'(n_acc), 32'd2);
        set_req(0, 1'b0, 12'h000, 12'h000, 1'b0);
        bus.rsp_ready = 1'b1;
        tick();
        chk_rsp("bp drain1", 13'h101, 0, 1'b1);
        tick();
        chk("bp drained", 32'(bus.rsp_valid), 32'd0);

        // Reset mid-burst with a beat sitting in S1.
        set_req(1, 1'b1, 12'hABC, 12'h123, 1'b0);
        #1;
        chk("mid grant", 32'(bus.req_ready), 32'h2);
        tick();
        set_req(1, 1'b0, 12'h000, 12'h000, 1'b0);
        set_req(3, 1'b1, 12'h7FF, 12'h001, 1'b1);
        #1;
        chk("mid locked busy", 32'(busy), 32'd1);
        chk("mid locked blocks 3", 32'(bus.req_ready), 32'h0);
        rst = 1'b1;
        #1;
        chk("async add_in", 32'(add_in), 32'd0);
        chk("async busy", 32'(busy), 32'd0);
        chk("async rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("async req_ready", 32'(bus.req_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("post-reset grant", 32'(bus.req_ready), 32'h8);
        tick();
        set_req(3, 1'b0, 12'h000, 12'h000, 1'b0);
        chk("discarded beat", 32'(bus.rsp_valid), 32'd0);
        tick();
        chk_rsp("post-reset rsp", 13'h800, 3, 1'b1);
        tick();
        chk("final drained", 32'(bus.rsp_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
